slowphy_iq_noise_packer: RTL and testbench

Writer-side packer for the slow-PHY-to-LLR path. It accepts one resource element (RE) per handshake: an I sample and a Q sample. It also accepts per-group noise samples. It packs both streams into 8-lane × 16-bit words and writes them into the IQ FIFO and the Noise FIFO that the LLR-side reader drains. Per user it writes exactly ceil(REs/4) IQ words and ceil(ceil(REs/rate)/8) noise words, zero-padding the final partial words, then pulses done.

---
 rtl/slowphy_pack_pkg.sv | 23 ++
 rtl/slowphy_lane_packer.sv | 78 +++++++
 rtl/slowphy_iq_noise_packer.sv | 157 +++++++++++++++
 tb/tb_slowphy_iq_noise_packer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slowphy_pack_pkg.sv
// Shared types and helpers for the slow-PHY IQ/noise writer-side packer.
package slowphy_pack_pkg;

    localparam int unsigned LANES = 8;
    localparam int unsigned RE_W  = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush,
        StDone
    } state_e;

    // ceil(num/den) with a zero denominator treated as one.
    function automatic logic [15:0] ceil_div(input logic [15:0] num, input logic [15:0] den);
        logic [16:0] d;
        logic [16:0] sum;
        d   = (den == 16'd0) ? 17'd1 : {1'b0, den};
        sum = {1'b0, num} + d - 17'd1;
        return 16'(sum / d);
    endfunction

endpackage

// File: rtl/slowphy_lane_packer.sv
// Generic 8-lane word accumulator: fills LanesPerAccept lanes per accept, zero-pads on last,
// holds the completed word in an output register until the FIFO takes it.
module slowphy_lane_packer
    import slowphy_pack_pkg::*;
#(
    parameter int unsigned LanesPerAccept = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           accept_i,
    input  logic [LanesPerAccept*RE_W-1:0] data_i,
    input  logic                           last_i,
    input  logic                           fifo_full_i,
    output logic                           wr_en_o,
    output logic [LANES*RE_W-1:0]          wr_data_o,
    output logic                           pending_o,
    output logic                           word_end_o
);

    localparam int unsigned SlotW = LanesPerAccept * RE_W;
    localparam int unsigned Slots = LANES / LanesPerAccept;
    localparam int unsigned IdxW  = $clog2(Slots);
    localparam int unsigned WordW = LANES * RE_W;

    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WordW-1:0] acc_q, acc_d, out_q, out_d, acc_fill;
    logic             pending_q, pending_d;
    logic             complete;

    assign word_end_o = (idx_q == IdxW'(Slots - 1)) || last_i;
    assign complete   = accept_i && word_end_o;
    assign wr_en_o    = pending_q && !fifo_full_i;
    assign wr_data_o  = out_q;
    assign pending_o  = pending_q;

    always_comb begin
        acc_fill  = acc_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        out_d     = out_q;
        pending_d = pending_q;
        for (int unsigned s = 0; s < Slots; s++) begin
            if (idx_q == IdxW'(s)) begin
                acc_fill[s*SlotW +: SlotW] = data_i;
            end
        end
        if (wr_en_o) begin
            pending_d = 1'b0;
        end
        // Accumulator is cleared on every completion, so unfilled lanes are already zero.
        if (accept_i) begin
            if (complete) begin
                idx_d     = '0;
                acc_d     = '0;
                out_d     = acc_fill;
                pending_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
                acc_d = acc_fill;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q     <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/slowphy_iq_noise_packer.sv
// Per-user IQ/noise packer: FSM, RE/noise budgets and two lane packers.
// Optional full-stall counters are built when SLOWPHY_PACK_STALL_CNT_EN is defined.
module slowphy_iq_noise_packer
    import slowphy_pack_pkg::*;
(
    input  logic                  i_core_clk,
    input  logic                  i_rx_rst,
    input  logic                  i_user_start,
    input  logic [15:0]           i_user_iq_noise_rate,
    input  logic [15:0]           i_cur_user_re_amounts,
    input  logic                  i_re_valid,
    output logic                  o_re_ready,
    input  logic [RE_W-1:0]       i_re_data_i,
    input  logic [RE_W-1:0]       i_re_data_q,
    input  logic                  i_noise_valid,
    output logic                  o_noise_ready,
    input  logic [RE_W-1:0]       i_noise_data,
    input  logic                  IQ_FIFO_Full,
    input  logic                  Noise_FIFO_Full,
    output logic                  IQ_FIFO_Write_Enable,
    output logic                  Noise_FIFO_Write_Enable,
    output logic [LANES*RE_W-1:0] IQ_Data_SUM,
    output logic [LANES*RE_W-1:0] Noise_Data_SUM,
    output logic                  o_busy,
    output logic                  o_user_done,
    output logic [15:0]           o_iq_stall_cnt,
    output logic [15:0]           o_noise_stall_cnt
);

    state_e      state_q, state_d;
    logic [15:0] re_left_q, re_left_d, noise_left_q, noise_left_d;
    logic        run, start_acc;
    logic        re_last, noise_last, re_accept, noise_accept;
    logic        iq_pending, noise_pending, iq_word_end, noise_word_end;

    assign run        = (state_q == StRun);
    assign start_acc  = i_user_start && (state_q == StIdle);
    assign re_last    = (re_left_q == 16'd1);
    assign noise_last = (noise_left_q == 16'd1);

    // Only back-pressure when the next accept would have to overwrite a word still held.
    assign o_re_ready    = run && (re_left_q != 16'd0)
                           && !(iq_pending && IQ_FIFO_Full && iq_word_end);
    assign o_noise_ready = run && (noise_left_q != 16'd0)
                           && !(noise_pending && Noise_FIFO_Full && noise_word_end);
    assign re_accept     = i_re_valid && o_re_ready;
    assign noise_accept  = i_noise_valid && o_noise_ready;

    assign o_busy      = run || (state_q == StFlush);
    assign o_user_done = (state_q == StDone);

    always_comb begin
        state_d      = state_q;
        re_left_d    = re_left_q;
        noise_left_d = noise_left_q;
        unique case (state_q)
            StIdle: begin
                if (i_user_start) begin
                    re_left_d    = i_cur_user_re_amounts;
                    noise_left_d = ceil_div(i_cur_user_re_amounts, i_user_iq_noise_rate);
                    state_d      = (i_cur_user_re_amounts == 16'd0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (re_accept) re_left_d = re_left_q - 16'd1;
                if (noise_accept) noise_left_d = noise_left_q - 16'd1;
                if ((re_left_q == 16'd0) && (noise_left_q == 16'd0)) state_d = StFlush;
            end
            StFlush: begin
                if (!iq_pending && !noise_pending) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            state_q      <= StIdle;
            re_left_q    <= '0;
            noise_left_q <= '0;
        end else begin
            state_q      <= state_d;
            re_left_q    <= re_left_d;
            noise_left_q <= noise_left_d;
        end
    end

    slowphy_lane_packer #(
        .LanesPerAccept(2)
    ) u_iq_packer (
        .clk_i      (i_core_clk),
        .rst_i      (i_rx_rst),
        .accept_i   (re_accept),
        .data_i     ({i_re_data_q, i_re_data_i}),
        .last_i     (re_last),
        .fifo_full_i(IQ_FIFO_Full),
        .wr_en_o    (IQ_FIFO_Write_Enable),
        .wr_data_o  (IQ_Data_SUM),
        .pending_o  (iq_pending),
        .word_end_o (iq_word_end)
    );

    slowphy_lane_packer #(
        .LanesPerAccept(1)
    ) u_noise_packer (
        .clk_i      (i_core_clk),
        .rst_i      (i_rx_rst),
        .accept_i   (noise_accept),
        .data_i     (i_noise_data),
        .last_i     (noise_last),
        .fifo_full_i(Noise_FIFO_Full),
        .wr_en_o    (Noise_FIFO_Write_Enable),
        .wr_data_o  (Noise_Data_SUM),
        .pending_o  (noise_pending),
        .word_end_o (noise_word_end)
    );

`ifdef SLOWPHY_PACK_STALL_CNT_EN
    logic [15:0] iq_stall_q, iq_stall_d, noise_stall_q, noise_stall_d;

    always_comb begin
        iq_stall_d    = iq_stall_q;
        noise_stall_d = noise_stall_q;
        if (start_acc) begin
            iq_stall_d    = '0;
            noise_stall_d = '0;
        end else begin
            if (iq_pending && IQ_FIFO_Full && (iq_stall_q != 16'hFFFF)) begin
                iq_stall_d = iq_stall_q + 16'd1;
            end
            if (noise_pending && Noise_FIFO_Full && (noise_stall_q != 16'hFFFF)) begin
                noise_stall_d = noise_stall_q + 16'd1;
            end
        end
    end

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            iq_stall_q    <= '0;
            noise_stall_q <= '0;
        end else begin
            iq_stall_q    <= iq_stall_d;
            noise_stall_q <= noise_stall_d;
        end
    end

    assign o_iq_stall_cnt    = iq_stall_q;
    assign o_noise_stall_cnt = noise_stall_q;
`else
    logic unused_start_acc;
    assign unused_start_acc  = start_acc;
    assign o_iq_stall_cnt    = '0;
    assign o_noise_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_slowphy_iq_noise_packer.sv
// Directed bench for slowphy_iq_noise_packer with a word-list model and per-cycle write checker.
module tb_slowphy_iq_noise_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  rate, amounts;
    logic         re_valid, re_ready, noise_valid, noise_ready;
    logic [15:0]  re_i, re_q, noise_d;
    logic         iq_full, noise_full;
    logic         iq_we, noise_we;
    logic [127:0] iq_data, noise_data;
    logic         busy, done;
    logic [15:0]  iq_stall, noise_stall;

    slowphy_iq_noise_packer dut (
        .i_core_clk             (clk),
        .i_rx_rst               (rst),
        .i_user_start           (start),
        .i_user_iq_noise_rate   (rate),
        .i_cur_user_re_amounts  (amounts),
        .i_re_valid             (re_valid),
        .o_re_ready             (re_ready),
        .i_re_data_i            (re_i),
        .i_re_data_q            (re_q),
        .i_noise_valid          (noise_valid),
        .o_noise_ready          (noise_ready),
        .i_noise_data           (noise_d),
        .IQ_FIFO_Full           (iq_full),
        .Noise_FIFO_Full        (noise_full),
        .IQ_FIFO_Write_Enable   (iq_we),
        .Noise_FIFO_Write_Enable(noise_we),
        .IQ_Data_SUM            (iq_data),
        .Noise_Data_SUM         (noise_data),
        .o_busy                 (busy),
        .o_user_done            (done),
        .o_iq_stall_cnt         (iq_stall),
        .o_noise_stall_cnt      (noise_stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model state: expected words for the current user plus observed write bookkeeping.
    logic [127:0] exp_iq[$];
    logic [127:0] exp_noise[$];
    logic [127:0] last_iq_word, last_noise_word, first_iq_word;
    int iq_wr_cnt, noise_wr_cnt, done_cnt, done_cyc, last_wr_cyc;
    int iq_first_cyc, iq_second_cyc;
    bit pat_small;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] re_i_val(input int k);
        return pat_small ? 16'(32'h11 + k) : 16'(k);
    endfunction

    function automatic logic [15:0] re_q_val(input int k);
        return pat_small ? 16'(32'h21 + k) : (16'(k) ^ 16'hA5A5);
    endfunction

    function automatic logic [15:0] noise_val(input int k);
        return 16'(32'h5000 + k);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("iq_we_while_full", 128'(iq_we & iq_full), 128'(0));
            check("noise_we_while_full", 128'(noise_we & noise_full), 128'(0));
            if (iq_we) begin
                if (exp_iq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL iq_extra_write: got %0h expected no write", iq_data);
                end else begin
                    check("iq_word", iq_data, exp_iq.pop_front());
                end
                if (iq_wr_cnt == 0) begin
                    iq_first_cyc  = cyc;
                    first_iq_word = iq_data;
                end
                if (iq_wr_cnt == 1) iq_second_cyc = cyc;
                iq_wr_cnt++;
                last_iq_word = iq_data;
                last_wr_cyc  = cyc;
            end
            if (noise_we) begin
                if (exp_noise.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL noise_extra_write: got %0h expected no write", noise_data);
                end else begin
                    check("noise_word", noise_data, exp_noise.pop_front());
                end
                noise_wr_cnt++;
                last_noise_word = noise_data;
                last_wr_cyc     = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic build_model(input int n, input int m);
        logic [127:0] w;
        exp_iq.delete();
        exp_noise.delete();
        for (int wi = 0; wi < (n + 3) / 4; wi++) begin
            w = '0;
            for (int k = 0; k < 4; k++) begin
                if (4 * wi + k < n) begin
                    w[32*k +: 16]    = re_i_val(4 * wi + k);
                    w[32*k+16 +: 16] = re_q_val(4 * wi + k);
                end
            end
            exp_iq.push_back(w);
        end
        for (int wi = 0; wi < (m + 7) / 8; wi++) begin
            w = '0;
            for (int k = 0; k < 8; k++) begin
                if (8 * wi + k < m) w[16*k +: 16] = noise_val(8 * wi + k);
            end
            exp_noise.push_back(w);
        end
    endtask

    task automatic drive_re(input int n);
        int k = 0;
        int guard = 0;
        bit acc;
        while (k < n && guard < 20000) begin
            re_valid = 1'b1;
            re_i = re_i_val(k);
            re_q = re_q_val(k);
            @(negedge clk);
            acc = re_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
            guard++;
        end
        re_valid = 1'b0;
        if (k < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL re_drive_timeout: got %0d accepted expected %0d", k, n);
        end
    endtask

    task automatic drive_noise(input int m);
        int k = 0;
        int guard = 0;
        bit acc;
        while (k < m && guard < 20000) begin
            noise_valid = 1'b1;
            noise_d = noise_val(k);
            @(negedge clk);
            acc = noise_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
            guard++;
        end
        noise_valid = 1'b0;
        if (k < m) begin
            n_checks++;
            n_fail++;
            $display("FAIL noise_drive_timeout: got %0d accepted expected %0d", k, m);
        end
    endtask

    // Holds IQ full for 40 cycles starting right after the first word completes.
    task automatic full_ctrl(input logic [127:0] word0);
        repeat (4) @(posedge clk);
        #1 iq_full = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("full_ready_drop", 128'(re_ready), 128'(0));
        check("full_data_held_early", iq_data, word0);
        repeat (36) @(posedge clk);
        @(negedge clk);
        check("full_data_held_late", iq_data, word0);
        check("full_we_low", 128'(iq_we), 128'(0));
        @(posedge clk);
        #1 iq_full = 1'b0;
    endtask

    task automatic start_user(input int n, input int r);
        iq_wr_cnt = 0;
        noise_wr_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        last_wr_cyc = -1;
        @(posedge clk);
        #1;
        start = 1'b1;
        amounts = 16'(n);
        rate = 16'(r);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_user(input int n, input int r, input bit full_test);
        int rr;
        int m;
        int start_cyc;
        int g;
        logic [127:0] word0;
        rr = (r == 0) ? 1 : r;
        m = (n + rr - 1) / rr;
        build_model(n, m);
        word0 = (n > 0) ? exp_iq[0] : '0;
        start_user(n, r);
        start_cyc = cyc;
        fork
            drive_re(n);
            drive_noise(m);
            if (full_test) full_ctrl(word0);
        join
        g = 0;
        while (done_cnt == 0 && g < 2000) begin
            @(posedge clk);
            g++;
        end
        if (done_cnt == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected one after %0d cycles", g);
        end
        repeat (4) @(posedge clk);
        #1;
        check("iq_write_count", 128'(iq_wr_cnt), 128'((n + 3) / 4));
        check("noise_write_count", 128'(noise_wr_cnt), 128'((m + 7) / 8));
        check("done_count", 128'(done_cnt), 128'(1));
        check("iq_words_left", 128'(exp_iq.size()), 128'(0));
        check("noise_words_left", 128'(exp_noise.size()), 128'(0));
        if (n > 0) check("done_after_last_write", 128'(done_cyc - last_wr_cyc), 128'(2));
        else check("zero_amount_done_latency", 128'(done_cyc - start_cyc), 128'(0));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        rate = '0;
        amounts = '0;
        re_valid = 1'b0;
        noise_valid = 1'b0;
        re_i = '0;
        re_q = '0;
        noise_d = '0;
        iq_full = 1'b0;
        noise_full = 1'b0;
        pat_small = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_iq_we", 128'(iq_we), 128'(0));
        check("rst_iq_data", iq_data, 128'(0));
        check("rst_noise_data", noise_data, 128'(0));
        check("rst_busy_done", 128'({busy, done}), 128'(0));
        check("rst_ready", 128'({re_ready, noise_ready}), 128'(0));
        check("rst_stall", 128'({iq_stall, noise_stall}), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Long user: 450 IQ words, 300 noise samples in 38 words.
        run_user(1797, 6, 1'b0);
        check("long_last_iq", last_iq_word, 128'h0000_0000_0000_0000_0000_0000_A2A1_0704);
        check("long_last_noise", last_noise_word, 128'h0000_0000_0000_0000_512B_512A_5129_5128);

        // Small literal pattern.
        pat_small = 1'b1;
        run_user(8, 4, 1'b0);
        check("small_word0", first_iq_word, 128'h0024_0014_0023_0013_0022_0012_0021_0011);
        check("iq_write_spacing", 128'(iq_second_cyc - iq_first_cyc), 128'(4));
        pat_small = 1'b0;

        // IQ FIFO full for 40 cycles with a word pending.
        run_user(16, 16, 1'b1);
`ifdef SLOWPHY_PACK_STALL_CNT_EN
        check("iq_stall_cnt", 128'(iq_stall), 128'(40));
`else
        check("iq_stall_cnt", 128'(iq_stall), 128'(0));
`endif
        check("noise_stall_cnt", 128'(noise_stall), 128'(0));

        run_user(0, 3, 1'b0);

        run_user(5, 0, 1'b0);
        check("rate0_noise_word", last_noise_word, 128'h0000_0000_0000_5004_5003_5002_5001_5000);

        // Reset after three REs of an 8-RE user; nothing may be written.
        exp_iq.delete();
        exp_noise.delete();
        start_user(8, 4);
        @(negedge clk);
        check("busy_in_run", 128'(busy), 128'(1));
        @(posedge clk);
        #1;
        drive_re(3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_we", 128'({iq_we, noise_we}), 128'(0));
        check("midrst_idle", 128'({busy, done, re_ready}), 128'(0));
        check("midrst_data", iq_data, 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        run_user(4, 4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
